// File: rtl/vector_split_pkg.sv
// Shared definitions for the vector split datapath: FSM states, packed-word
// field bounds and the byte-reversal helper also used on the append side.
package vector_split_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } state_t;

  localparam int A_HI   = 63;
  localparam int A_LO   = 32;
  localparam int PAD_HI = 31;
  localparam int PAD_LO = 24;
  localparam int B_HI   = 23;

  function automatic logic [31:0] byte_reverse32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/vector_split_fields.sv
// Combinational slicer: splits a packed word into the restored A field,
// the B field and a pad-byte nonzero indication.
module vector_split_fields
  import vector_split_pkg::*;
#(
  parameter int BYTE_SWAP = 1
) (
  input  logic [63:0] word,
  output logic [31:0] a,
  output logic [23:0] b,
  output logic        pad_nonzero
);

  if (BYTE_SWAP != 0) begin : g_swap
    assign a = byte_reverse32(word[A_HI:A_LO]);
  end else begin : g_pass
    assign a = word[A_HI:A_LO];
  end

  assign b           = word[B_HI:0];
  assign pad_nonzero = |word[PAD_HI:PAD_LO];

endmodule

// File: rtl/vector_split.sv
// Streaming unpacker: one 64-bit word in, an A beat then a B beat out,
// with a sticky pad-byte error flag and a completed-word counter.
module vector_split
  import vector_split_pkg::*;
#(
  parameter int BYTE_SWAP = 1,
  parameter int CNT_W     = 16,
  parameter int CHECK_PAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_tag,
  output logic             out_last,
  input  logic             clr_err,
  output logic             pad_err,
  output logic [CNT_W-1:0] word_count
);

  logic [31:0]      a_field;
  logic [23:0]      b_field;
  logic             pad_nonzero;

  state_t           state_reg;
  state_t           state_next;
  logic [31:0]      a_reg;
  logic [23:0]      b_reg;
  logic             pad_err_reg;
  logic [CNT_W-1:0] count_reg;

  logic             ready_int;
  logic             load;
  logic             b_done;
  logic             pad_hit;

  // Slicing happens on the incoming word; only the A and B fields are kept,
  // so the pad byte can never reach out_data.
  vector_split_fields #(
    .BYTE_SWAP(BYTE_SWAP)
  ) u_fields (
    .word       (in_data),
    .a          (a_field),
    .b          (b_field),
    .pad_nonzero(pad_nonzero)
  );

  always_comb begin
    state_next = state_reg;
    ready_int  = 1'b0;
    out_valid  = 1'b0;
    out_tag    = 1'b0;
    out_last   = 1'b0;
    out_data   = 32'h0;
    case (state_reg)
      IDLE: begin
        ready_int = 1'b1;
        if (in_valid) state_next = EMIT_A;
      end
      EMIT_A: begin
        out_valid = 1'b1;
        out_data  = a_reg;
        if (out_ready) state_next = EMIT_B;
      end
      EMIT_B: begin
        out_valid = 1'b1;
        out_tag   = 1'b1;
        out_last  = 1'b1;
        out_data  = {8'h00, b_reg};
        // Accepting the next word while the B beat leaves avoids a bubble.
        ready_int = out_ready;
        if (out_ready) state_next = in_valid ? EMIT_A : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load    = in_valid && ready_int;
  assign b_done  = (state_reg == EMIT_B) && out_ready;
  assign pad_hit = (CHECK_PAD != 0) && load && pad_nonzero;

  // State resets to IDLE, which would otherwise advertise ready during reset.
  assign in_ready   = ready_int && rst;
  assign pad_err    = pad_err_reg;
  assign word_count = count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      a_reg       <= 32'h0;
      b_reg       <= 24'h0;
      pad_err_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_reg <= a_field;
        b_reg <= b_field;
      end
      // A fresh violation takes priority over a simultaneous clear.
      if (pad_hit)      pad_err_reg <= 1'b1;
      else if (clr_err) pad_err_reg <= 1'b0;
      if (b_done) count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule
